seg7_display_driver: RTL

Scanning seven-segment driver that consumes the 32-bit `display_data` word produced by the processor datapath's register file and shows it as eight hexadecimal digits on a common-anode, time-multiplexed board display. It sits directly downstream of the datapath at the top level. It snapshots the word once per scan so that a digit pattern never tears mid-frame. It also supports freezing the shown value and blanking leading zeros.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_display_driver_hex_to_seg7.sv | 11 +
 rtl/seg7_display_driver.sv | 77 +++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanning seven-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Entry n is the active-low pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic [6:0]            seg;
        logic                  dp;
    } seg7_out_t;

    // Position of the highest non-zero nibble; 0 when the word is all zero.
    function automatic logic [2:0] msd_of(input logic [31:0] word);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[4*i +: 4] != 4'h0) m = 3'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_display_driver_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_display_driver.sv
// Time-multiplexed eight-digit hex display driver with per-frame snapshot,
// freeze and leading-zero blanking.
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           display_data,
    input  logic                  freeze,
    input  logic                  blank_lz,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      snap;
    logic             load_pend;
    seg7_out_t        out_q;

    logic       digit_wrap;
    logic       frame_wrap;
    logic       do_load;
    logic [2:0] msd;
    logic       blank;
    logic [3:0] nib;
    logic [6:0] dec_seg;

    assign digit_wrap = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign frame_wrap = digit_wrap && (idx == 3'd7);
    assign do_load    = (frame_wrap || load_pend) && !freeze;

    assign msd   = msd_of(snap);
    assign blank = blank_lz && (idx > msd);
    assign nib   = snap[{idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            idx       <= 3'd0;
            snap      <= 32'h0;
            load_pend <= 1'b1;
            out_q     <= '{an: '1, seg: SEG_BLANK, dp: 1'b1};
        end else begin
            div_cnt <= digit_wrap ? '0 : div_cnt + DIV_W'(1);
            if (digit_wrap) idx <= idx + 3'd1;

            // A frame boundary missed while frozen is remembered so the
            // load happens as soon as freeze drops.
            if (do_load) begin
                snap      <= display_data;
                load_pend <= 1'b0;
            end else if (frame_wrap) begin
                load_pend <= 1'b1;
            end

            out_q.an  <= ~(NUM_DIGITS'(1) << idx);
            out_q.seg <= blank ? SEG_BLANK : dec_seg;
            out_q.dp  <= 1'b1;
        end
    end

    assign an  = out_q.an;
    assign seg = out_q.seg;
    assign dp  = out_q.dp;

endmodule
